conv_window_fetch: RTL and testbench

Upstream feeder for the 128x128 3x3 convolution datapath (the TOP/FSM that produces the 20-bit result with start/done).
- Walks the image in raster order and reads pixels from a synchronous image memory (1-cycle read latency).
- Assembles each 3x3 neighbourhood with zero padding at the borders.
- Hands each window to the convolution stage over a valid/ready handshake.
- Pulses done after the last window has been accepted.

---
 rtl/conv_window_fetch.sv | 158 +++++++++++++++
 tb/tb_conv_window_fetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_fetch.sv
// conv_window_fetch: walks the image in raster order and assembles zero-padded 3x3 windows for the convolution stage.
// Optional macro WIN_REUSE_EN: when stepping right, reuse two columns of the previous window and fetch only the new one.

module conv_window_fetch #(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic                 mem_rd_en,
   input  logic [PIX_W-1:0]     mem_data,
   output logic [9*PIX_W-1:0]   win_data,
   output logic [6:0]           win_row,
   output logic [6:0]           win_col,
   output logic                 win_valid,
   input  logic                 win_ready,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPT, S_VALID, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [6:0]       row_q, row_d, col_q, col_d;
   logic [3:0]       tapIdx_q, tapIdx_d;
   logic             pendValid_q, pendValid_d;
   logic             pendInb_q, pendInb_d;
   logic [3:0]       pendIdx_q, pendIdx_d;
   logic [PIX_W-1:0] tap_q [9];
   logic [PIX_W-1:0] tap_d [9];

   int               tapRow, tapCol;
   logic             tapInb;
   logic [ADDR_W-1:0] tapAddr;
   logic             lastCol, lastWin;
   logic [6:0]       nextRow, nextCol;
   logic [3:0]       tapStep, firstTap;

   always_comb begin
      tapRow  = int'(row_q) + int'(tapIdx_q) / 3 - 1;
      tapCol  = int'(col_q) + int'(tapIdx_q) % 3 - 1;
      tapInb  = (tapRow >= 0) && (tapRow < IMG_H) && (tapCol >= 0) && (tapCol < IMG_W);
      tapAddr = tapInb ? ADDR_W'(tapRow * IMG_W + tapCol) : '0;
   end

   // Raster advance and the tap schedule of the next fetch
   always_comb begin
      lastCol  = (col_q == 7'(IMG_W - 1));
      lastWin  = lastCol && (row_q == 7'(IMG_H - 1));
      nextCol  = lastCol ? 7'd0 : col_q + 7'd1;
      nextRow  = lastCol ? (lastWin ? 7'd0 : row_q + 7'd1) : row_q;
      tapStep  = 4'd1;
      firstTap = 4'd0;
`ifdef WIN_REUSE_EN
      if (col_q != 7'd0) begin
         tapStep = 4'd3;
      end
      if (!lastCol) begin
         firstTap = 4'd2;
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      tapIdx_d    = tapIdx_q;
      pendValid_d = 1'b0;
      pendIdx_d   = tapIdx_q;
      pendInb_d   = tapInb;
      tap_d       = tap_q;
      // Read data lands one cycle after its strobe; padded taps load zero at the same point
      if (pendValid_q) begin
         tap_d[pendIdx_q] = pendInb_q ? mem_data : '0;
      end
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_FETCH;
               row_d    = 7'd0;
               col_d    = 7'd0;
               tapIdx_d = 4'd0;
            end
         end
         S_FETCH: begin
            pendValid_d = 1'b1;
            if (tapIdx_q == 4'd8) begin
               state_d = S_CAPT;
            end else begin
               tapIdx_d = tapIdx_q + tapStep;
            end
         end
         S_CAPT: state_d = S_VALID;
         S_VALID: begin
            if (win_ready) begin
               row_d    = nextRow;
               col_d    = nextCol;
               tapIdx_d = firstTap;
               state_d  = lastWin ? S_DONE : S_FETCH;
`ifdef WIN_REUSE_EN
               if (!lastCol) begin
                  for (int k = 0; k < 3; k++) begin
                     tap_d[3*k]     = tap_q[3*k+1];
                     tap_d[3*k + 1] = tap_q[3*k+2];
                  end
               end
`endif
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         row_q       <= 7'd0;
         col_q       <= 7'd0;
         tapIdx_q    <= 4'd0;
         pendValid_q <= 1'b0;
         pendInb_q   <= 1'b0;
         pendIdx_q   <= 4'd0;
         for (int k = 0; k < 9; k++) begin
            tap_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         tapIdx_q    <= tapIdx_d;
         pendValid_q <= pendValid_d;
         pendInb_q   <= pendInb_d;
         pendIdx_q   <= pendIdx_d;
         tap_q       <= tap_d;
      end
   end

   always_comb begin
      mem_rd_en = (state_q == S_FETCH) && tapInb;
      mem_addr  = mem_rd_en ? tapAddr : '0;
      win_valid = (state_q == S_VALID);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      win_row   = row_q;
      win_col   = col_q;
      win_data  = '0;
      for (int k = 0; k < 9; k++) begin
         win_data[k*PIX_W +: PIX_W] = tap_q[k];
      end
   end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Scoreboard bench for conv_window_fetch: a full-size instance for positional scenarios and a small
// instance (8x6) for complete-frame timing, done pulse and start-while-busy.

module tb_conv_window_fetch;

   localparam int BW = 128, BH = 128;
   localparam int SW = 8,   SH = 6;

   localparam logic [71:0] CORNER = {8'd129, 8'd128, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
   localparam logic [71:0] MID    = {8'd11, 8'd10, 8'd9, 8'd139, 8'd138, 8'd137, 8'd11, 8'd10, 8'd9};
   localparam logic [71:0] SLAST  = {8'd0, 8'd0, 8'd0, 8'd0, 8'd47, 8'd46, 8'd0, 8'd39, 8'd38};

   typedef struct packed {
      logic [6:0]  row;
      logic [6:0]  col;
      logic [71:0] data;
   } win_t;

   logic        clk = 1'b0;
   logic        rst;

   logic        bStart, bRdEn, bValid, bReady, bBusy, bDone;
   logic [13:0] bAddr;
   logic [7:0]  bData;
   logic [71:0] bWin;
   logic [6:0]  bRow, bCol;

   logic        sStart, sRdEn, sValid, sReady, sBusy, sDone;
   logic [5:0]  sAddr;
   logic [7:0]  sData;
   logic [71:0] sWin;
   logic [6:0]  sRow, sCol;

   win_t bq[$];
   win_t sq[$];
   int   compared = 0;
   int   mismatched = 0;
   int   bXfer = 0;
   int   sXfer = 0;
   logic recRd = 1'b0;
   int   rdAddrs[$];

   always #5 clk = ~clk;

   conv_window_fetch #(.IMG_W(BW), .IMG_H(BH), .PIX_W(8), .ADDR_W(14)) dutBig (
      .clk(clk), .rst(rst), .start(bStart), .mem_addr(bAddr), .mem_rd_en(bRdEn), .mem_data(bData),
      .win_data(bWin), .win_row(bRow), .win_col(bCol), .win_valid(bValid), .win_ready(bReady),
      .busy(bBusy), .done(bDone)
   );

   conv_window_fetch #(.IMG_W(SW), .IMG_H(SH), .PIX_W(8), .ADDR_W(6)) dutSmall (
      .clk(clk), .rst(rst), .start(sStart), .mem_addr(sAddr), .mem_rd_en(sRdEn), .mem_data(sData),
      .win_data(sWin), .win_row(sRow), .win_col(sCol), .win_valid(sValid), .win_ready(sReady),
      .busy(sBusy), .done(sDone)
   );

   // Image memories: pixel value is the address mod 256, one cycle of read latency
   always @(posedge clk) begin
      if (bRdEn) bData <= bAddr[7:0];
      if (sRdEn) sData <= {2'b00, sAddr};
   end

   always @(negedge clk) begin
      if (recRd && bRdEn) rdAddrs.push_back(int'(bAddr));
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s", name);
   endtask

   function automatic logic [71:0] modelWin(input int r, input int c, input int w, input int h);
      logic [71:0] d;
      int rr, cc;
      d = '0;
      for (int k = 0; k < 9; k++) begin
         rr = r + k / 3 - 1;
         cc = c + k % 3 - 1;
         if (rr >= 0 && rr < h && cc >= 0 && cc < w) d[k*8 +: 8] = 8'((rr * w + cc) % 256);
      end
      return d;
   endfunction

   // Monitors pop the next expected window on every transfer
   always @(negedge clk) begin
      win_t e;
      if (!rst && bValid && bReady) begin
         if (bq.size() == 0) begin
            failNow($sformatf("big unexpected window (%0d,%0d)", bRow, bCol));
         end else begin
            e = bq.pop_front();
            checkOutput($sformatf("big win(%0d,%0d)", e.row, e.col), {bRow, bCol, bWin}, e);
         end
         bXfer++;
      end
   end

   always @(negedge clk) begin
      win_t e;
      if (!rst && sValid && sReady) begin
         if (sq.size() == 0) begin
            failNow($sformatf("small unexpected window (%0d,%0d)", sRow, sCol));
         end else begin
            e = sq.pop_front();
            checkOutput($sformatf("small win(%0d,%0d)", e.row, e.col), {sRow, sCol, sWin}, e);
         end
         sXfer++;
      end
   end

   task automatic applyStimulus(input bit big, output time t0);
      if (big) bStart = 1'b1; else sStart = 1'b1;
      @(posedge clk);
      t0 = $time;
      #1;
      bStart = 1'b0;
      sStart = 1'b0;
   endtask

   task automatic waitWindow(input bit big, input int r, input int c, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (big ? (bValid && bRow == 7'(r) && bCol == 7'(c)) : (sValid && sRow == 7'(r) && sCol == 7'(c))) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) failNow($sformatf("timeout waiting for window (%0d,%0d)", r, c));
   endtask

   initial begin
      win_t e;
      bit   ok, gotDone;
      time  t0;
      int   cycles, expCycles, n;
      int   expRd[4] = '{0, 1, 128, 129};

      rst = 1'b1;
      bStart = 1'b0; sStart = 1'b0;
      bReady = 1'b1; sReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset big outputs", {bAddr, bRdEn, bWin, bRow, bCol, bValid, bBusy, bDone}, '0);
      checkOutput("reset small outputs", {sAddr, sRdEn, sWin, sRow, sCol, sValid, sBusy, sDone}, '0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Small frame: complete raster, a start pulse mid-frame, timing and done pulse
      for (int r = 0; r < SH; r++) begin
         for (int c = 0; c < SW; c++) begin
            e.row  = 7'(r);
            e.col  = 7'(c);
            e.data = (r == SH - 1 && c == SW - 1) ? SLAST : modelWin(r, c, SW, SH);
            sq.push_back(e);
         end
      end
`ifdef WIN_REUSE_EN
      expCycles = SH * 11 + SH * (SW - 1) * 5;
`else
      expCycles = SW * SH * 11;
`endif
      applyStimulus(1'b0, t0);
      waitWindow(1'b0, 2, 2, 400, ok);
      if (ok) begin
         sStart = 1'b1;
         @(posedge clk);
         #1;
         sStart = 1'b0;
      end
      gotDone = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         if (sDone) begin
            gotDone = 1'b1;
            break;
         end
      end
      if (!gotDone) begin
         failNow("small frame done never seen");
      end else begin
         cycles = int'(($time - 1 - t0) / 10);
         compared++;
         if (cycles < expCycles - 1 || cycles > expCycles + 1) begin
            mismatched++;
            $display("[TB] FAIL small frame cycles: got %0d, expected %0d", cycles, expCycles);
         end
         checkOutput("small transfer count", 128'(sXfer), 128'(SW * SH));
         checkOutput("small queue drained", 128'(sq.size()), '0);
         @(posedge clk);
         #1;
         checkOutput("small done single pulse", {sDone, sBusy}, '0);
      end

      // Large frame: corner reads, backpressure at (0,3), run to (40,77) and reset
      for (n = 0; n < 40 * BW + 77; n++) begin
         e.row  = 7'(n / BW);
         e.col  = 7'(n % BW);
         e.data = (n == 0) ? CORNER : (n == 5 * BW + 10) ? MID : modelWin(n / BW, n % BW, BW, BH);
         bq.push_back(e);
      end
      recRd = 1'b1;
      applyStimulus(1'b1, t0);
      waitWindow(1'b1, 0, 0, 20, ok);
      recRd = 1'b0;
      checkOutput("corner read count", 128'(rdAddrs.size()), 128'(4));
      if (rdAddrs.size() == 4) begin
         for (int i = 0; i < 4; i++) checkOutput($sformatf("corner read addr %0d", i), 128'(rdAddrs[i]), 128'(expRd[i]));
      end

      waitWindow(1'b1, 0, 3, 100, ok);
      if (ok) begin
         bReady = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("backpressure window held", {bValid, bRow, bCol, bWin}, {1'b1, 7'd0, 7'd3, modelWin(0, 3, BW, BH)});
            checkOutput("backpressure no read", bRdEn, 1'b0);
         end
         @(posedge clk);
         #1;
         bReady = 1'b1;
      end

      waitWindow(1'b1, 40, 77, 60000, ok);
      if (ok) begin
         rst = 1'b1;
         #1;
         checkOutput("async reset mid-frame", {bAddr, bRdEn, bWin, bRow, bCol, bValid, bBusy, bDone}, '0);
         checkOutput("big queue drained at reset", 128'(bq.size()), '0);
         checkOutput("big transfers before reset", 128'(bXfer), 128'(40 * BW + 77));
         repeat (2) @(posedge clk);
         #1;
         rst = 1'b0;
         @(posedge clk);
         #1;
         e.row = 7'd0; e.col = 7'd0; e.data = CORNER;
         bq.push_back(e);
         applyStimulus(1'b1, t0);
         waitWindow(1'b1, 0, 0, 20, ok);
         repeat (2) @(posedge clk);
         #1;
         checkOutput("restart corner consumed", 128'(bq.size()), '0);
         checkOutput("restart busy", bBusy, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
